// File: rtl/packet_queue_if.sv
// Producer/consumer handshake bundle for packet_queue: slave is the queue, master is the environment.
interface packet_queue_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned HEADER_W = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                io_in_valid;
    logic                io_in_ready;
    logic [DATA_W-1:0]   io_in_data;
    logic [HEADER_W-1:0] io_in_header;
    logic [ADDR_W-1:0]   io_in_addr;
    logic                io_out_valid;
    logic                io_out_ready;
    logic [DATA_W-1:0]   io_out_data;
    logic [HEADER_W-1:0] io_out_header;
    logic [ADDR_W-1:0]   io_out_addr;
    logic [CNT_W-1:0]    io_count;

    modport master (
        output io_in_valid, io_in_data, io_in_header, io_in_addr, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_header, io_out_addr, io_count
    );

    modport slave (
        input  io_in_valid, io_in_data, io_in_header, io_in_addr, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_header, io_out_addr, io_count
    );
endinterface

// File: rtl/packet_queue.sv
// Elastic ready/valid packet FIFO of DEPTH {data, header, addr} entries.
// Optional zero-latency pass-through when empty: define PACKET_QUEUE_BYPASS_EN.
module packet_queue #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned HEADER_W = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4
) (
    input  logic         clock,
    input  logic         reset,
    packet_queue_if.slave io
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [HEADER_W-1:0] header;
        logic [ADDR_W-1:0]   addr;
    } packet_t;

    packet_t          mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    packet_t inPkt;
    packet_t outPkt;
    logic    empty;
    logic    full;
    logic    inReady;
    logic    outValid;
    logic    inFire;
    logic    outFire;
    logic    storeFire;
    logic    popFire;

    // Handshake decode; every output is forced quiet while reset is high.
    always_comb begin
        inPkt.data   = io.io_in_data;
        inPkt.header = io.io_in_header;
        inPkt.addr   = io.io_in_addr;
        empty        = (count == '0);
        full         = (count == CNT_W'(DEPTH));
        inReady      = !reset && !full;
`ifdef PACKET_QUEUE_BYPASS_EN
        outValid     = !reset && (empty ? io.io_in_valid : 1'b1);
        outPkt       = empty ? inPkt : mem[rdPtr];
`else
        outValid     = !reset && !empty;
        outPkt       = mem[rdPtr];
`endif
        if (!outValid) begin
            outPkt = '0;
        end
        inFire  = io.io_in_valid && inReady;
        outFire = outValid && io.io_out_ready;
`ifdef PACKET_QUEUE_BYPASS_EN
        // A pass-through packet neither lands in storage nor leaves from it.
        storeFire = inFire && !(empty && outFire);
        popFire   = outFire && !empty;
`else
        storeFire = inFire;
        popFire   = outFire;
`endif
    end

    assign io.io_in_ready   = inReady;
    assign io.io_out_valid  = outValid;
    assign io.io_out_data   = outPkt.data;
    assign io.io_out_header = outPkt.header;
    assign io.io_out_addr   = outPkt.addr;
    assign io.io_count      = reset ? '0 : count;

    // Storage is intentionally not reset; count/pointers gate its visibility.
    always_ff @(posedge clock) begin
        if (storeFire) begin
            mem[wrPtr] <= inPkt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (storeFire) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            unique case ({storeFire, popFire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
